alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

ALU command issuer and result collector: the initiator side of the ALU operand/result interface (`op_code`, `src1..3`, `srcCy`, `srcAc`, `bit_in`, `valid_in` out; `des1..3`, `des_acc`, `desCy`, `desAC`, `desOv`, `valid_out` in). It buffers commands from the core sequencer and issues one operation at a time to the ALU. It waits for the result, with a timeout, and returns it on a ready/valid response port. It maintains a PSW flag register that can feed carry and aux-carry into the next operation.

## Interface
- `CMD_DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `TIMEOUT`, 16: maximum WAIT cycles before an error response; range 2..255.
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_op` in 4, `cmd_src1`/`cmd_src2`/`cmd_src3` in 8 each, `cmd_cy` in 1, `cmd_ac` in 1, `cmd_bit` in 1: command fields.
- `cmd_use_psw` in 1: when 1, drive `srcCy`/`srcAc` from the PSW; when 0, use `cmd_cy`/`cmd_ac`.
- `op_code` out 4, `src1`/`src2`/`src3` out 8 each, `srcCy` out 1, `srcAc` out 1, `bit_in` out 1, `valid_in` out 1: ALU request.
- `des1`/`des2`/`des3`/`des_acc` in 8 each, `desCy`/`desAC`/`desOv` in 1 each, `valid_out` in 1: ALU result.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_des1`/`rsp_des2`/`rsp_des3`/`rsp_acc` out 8 each, `rsp_err` out 1: response payload. `rsp_err` = 1 means timeout.
- `psw_cy`, `psw_ac`, `psw_ov` out 1 each: current PSW flags.
- `err_spurious` out 1: sticky; set by `valid_out` outside WAIT.

## Operation
- A command is written to the FIFO when `cmd_valid && cmd_ready`.
- `cmd_ready` = FIFO not full. It is combinational from FIFO state and is 1 after reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if the FIFO is non-empty, pop the head, register the ALU request fields (resolving `srcCy`/`srcAc` from `cmd_use_psw` against the PSW as it is at pop time), then go to ISSUE.
- ISSUE: `valid_in` = 1 for exactly one cycle with the registered fields; go to WAIT. The request fields hold their value until the next pop.
- WAIT: clear the timeout counter on entry; the counter increments each WAIT cycle.
  - `valid_out` = 1: capture `des1..3` and `des_acc`; load PSW from `desCy`/`desAC`/`desOv`; set `rsp_err` = 0; go to RESP.
  - Otherwise, when the counter reaches `TIMEOUT`-1: zero the response data; set `rsp_err` = 1; leave the PSW unchanged; go to RESP.
  - If `valid_out` and the timeout condition occur in the same cycle, `valid_out` wins.
- RESP: `rsp_valid` = 1, with payload held stable, until `rsp_ready`. On the handshake, go to IDLE.
- The ALU is only sampled in WAIT. `valid_out` in IDLE, ISSUE or RESP is ignored and sets `err_spurious`; only reset clears it.
- Only one operation is outstanding at a time. The FIFO keeps accepting commands in every state.
- A PSW update takes effect before the next pop, so back-to-back `cmd_use_psw` commands chain carry correctly.

## Timing
- Reset values: all ALU request outputs 0, `valid_in` 0, `rsp_*` 0, PSW 0, `err_spurious` 0, FSM in IDLE, FIFO empty.
- Asserting `reset` mid-operation drops `valid_in`/`rsp_valid` immediately and discards FIFO contents. A later `valid_out` from the ALU for the aborted operation sets `err_spurious`.
- Command accepted in cycle 0 into an empty FIFO with FSM in IDLE: pop in cycle 1, `valid_in` in cycle 2, WAIT from cycle 3.
- `valid_out` in cycle k (k ≥ 3) gives `rsp_valid` in cycle k+1.
- Minimum command-to-command issue spacing is 4 cycles when `rsp_ready` is held at 1.
- FIFO full with a simultaneous pop: `cmd_ready` stays 0 in that cycle because it reflects registered state only.
- Timeout: with no `valid_out`, `rsp_valid` with `rsp_err` rises `TIMEOUT`+1 cycles after `valid_in`.

## Structure
- Shared package `alu_pkg`: `alu_op_t` (4-bit opcode enum), `alu_req_t` struct (op, src1..3, cy, ac, bit), `alu_flags_t` struct (cy, ac, ov), `issue_state_t` enum.
- Sub-module `alu_cmd_fifo`: synchronous FIFO of `alu_req_t` plus the `use_psw` bit, with `CMD_DEPTH` entries and wrap-around pointers plus an extra bit for the full/empty distinction.

## Test plan
- Single op: op=4'h1, src1=8'h0F, src2=8'h01, `cmd_use_psw`=0. The stub ALU returns des1=8'h10 and desCy=0 three cycles after `valid_in`. Expect `valid_in` in cycle 2, `rsp_des1`=8'h10, `rsp_err`=0.
- Carry chaining: two commands with `cmd_use_psw`=1. The first returns desCy=1. Expect the second issue to drive `srcCy`=1 and `psw_cy`=1.
- Timeout: `TIMEOUT`=4 and the ALU never responds. Expect `rsp_valid` with `rsp_err`=1, data 8'h00, and the PSW unchanged, 5 cycles after `valid_in`.
- Backpressure and full: hold `rsp_ready`=0 and push 5 commands with `CMD_DEPTH`=4. Expect `cmd_ready`=0 after 4 are buffered. The payload must hold stable, with all 5 responses in order once `rsp_ready`=1.
- Spurious `valid_out` pulsed in IDLE: expect `err_spurious`=1 and no response.
- Reset asserted during WAIT: expect all outputs at their reset values immediately and the FIFO empty. The first command after release issues with the PSW at 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller: opcodes, request/response
// payloads, PSW flag bundle and the issue FSM state encoding.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_ADDC = 4'h2, OP_SUB = 4'h3,
        OP_INC  = 4'h4, OP_DEC = 4'h5, OP_MUL  = 4'h6, OP_DIV = 4'h7,
        OP_DA   = 4'h8, OP_NOT = 4'h9, OP_AND  = 4'hA, OP_XRL = 4'hB,
        OP_OR   = 4'hC, OP_RL  = 4'hD, OP_RLC  = 4'hE, OP_RR  = 4'hF
    } alu_op_t;

    typedef struct packed {
        alu_op_t    op;
        logic [7:0] src1;
        logic [7:0] src2;
        logic [7:0] src3;
        logic       cy;
        logic       ac;
        logic       bit_in;
    } alu_req_t;

    typedef struct packed {
        logic cy;
        logic ac;
        logic ov;
    } alu_flags_t;

    typedef struct packed {
        logic [7:0] des1;
        logic [7:0] des2;
        logic [7:0] des3;
        logic [7:0] acc;
        logic       err;
    } alu_rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } issue_state_t;

    localparam int TMR_W = 8;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command buffer between the core sequencer and the issue FSM.
// Ports:
//   clk, reset        clock, async active-low reset (empties the FIFO)
//   push_i            write request; ignored while full
//   push_req_i        request fields to store
//   push_use_psw_i    per-command "take carry/aux-carry from PSW" flag
//   pop_i             read request; ignored while empty
//   head_req_o        request at the head of the queue
//   head_use_psw_o    use_psw flag at the head of the queue
//   full_o, empty_o   status from registered pointers only
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push_i,
    input  alu_req_t push_req_i,
    input  logic     push_use_psw_i,
    input  logic     pop_i,
    output alu_req_t head_req_o,
    output logic     head_use_psw_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    alu_req_t    mem_req_q [DEPTH];
    logic        mem_psw_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_req_q[wr_ptr_q[AW-1:0]] <= push_req_i;
            mem_psw_q[wr_ptr_q[AW-1:0]] <= push_use_psw_i;
        end
    end

    assign head_req_o     = mem_req_q[rd_ptr_q[AW-1:0]];
    assign head_use_psw_o = mem_psw_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU command issuer / result collector. Buffers sequencer commands, issues
// one ALU operation at a time, waits for the result with a timeout, returns
// it on a ready/valid response port and keeps a PSW (cy/ac/ov) that can feed
// the next operation's carry inputs.
// Ports:
//   clk, reset                         clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_*         command handshake and fields
//   op_code, src1..3, srcCy, srcAc,
//   bit_in, valid_in                   ALU request
//   des1..3, des_acc, desCy, desAC,
//   desOv, valid_out                   ALU result
//   rsp_valid/rsp_ready, rsp_*         response handshake and payload
//   psw_cy, psw_ac, psw_ov             current PSW flags
//   err_spurious                       sticky: valid_out seen outside WAIT
//
// state | meaning
// IDLE  | waiting for a buffered command; pops and latches request fields
// ISSUE | valid_in high for this single cycle
// WAIT  | sampling the ALU, timeout counter running
// RESP  | response held on rsp_* until rsp_ready
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_src1,
    input  logic [7:0] cmd_src2,
    input  logic [7:0] cmd_src3,
    input  logic       cmd_cy,
    input  logic       cmd_ac,
    input  logic       cmd_bit,
    input  logic       cmd_use_psw,
    output logic [3:0] op_code,
    output logic [7:0] src1,
    output logic [7:0] src2,
    output logic [7:0] src3,
    output logic       srcCy,
    output logic       srcAc,
    output logic       bit_in,
    output logic       valid_in,
    input  logic [7:0] des1,
    input  logic [7:0] des2,
    input  logic [7:0] des3,
    input  logic [7:0] des_acc,
    input  logic       desCy,
    input  logic       desAC,
    input  logic       desOv,
    input  logic       valid_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_des1,
    output logic [7:0] rsp_des2,
    output logic [7:0] rsp_des3,
    output logic [7:0] rsp_acc,
    output logic       rsp_err,
    output logic       psw_cy,
    output logic       psw_ac,
    output logic       psw_ov,
    output logic       err_spurious
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    issue_state_t     state_q, state_d;
    alu_req_t         req_q, req_d;
    alu_flags_t       psw_q, psw_d;
    alu_rsp_t         rsp_q, rsp_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             spur_q, spur_d;

    alu_req_t cmd_req;
    alu_req_t head_req;
    logic     head_use_psw;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_pop;

    always_comb begin
        cmd_req        = '0;
        cmd_req.op     = alu_op_t'(cmd_op);
        cmd_req.src1   = cmd_src1;
        cmd_req.src2   = cmd_src2;
        cmd_req.src3   = cmd_src3;
        cmd_req.cy     = cmd_cy;
        cmd_req.ac     = cmd_ac;
        cmd_req.bit_in = cmd_bit;
    end

    alu_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .push_i         (cmd_valid),
        .push_req_i     (cmd_req),
        .push_use_psw_i (cmd_use_psw),
        .pop_i          (fifo_pop),
        .head_req_o     (head_req),
        .head_use_psw_o (head_use_psw),
        .full_o         (fifo_full),
        .empty_o        (fifo_empty)
    );

    assign cmd_ready = !fifo_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            psw_q   <= '0;
            rsp_q   <= '0;
            tmr_q   <= '0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            psw_q   <= psw_d;
            rsp_q   <= rsp_d;
            tmr_q   <= tmr_d;
            spur_q  <= spur_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        psw_d    = psw_q;
        rsp_d    = rsp_q;
        tmr_d    = tmr_q;
        fifo_pop = 1'b0;
        spur_d   = spur_q | (valid_out && (state_q != ST_WAIT));

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    req_d    = head_req;
                    // PSW is read here, at pop time, so a result written in
                    // the previous WAIT already feeds this operation.
                    if (head_use_psw) begin
                        req_d.cy = psw_q.cy;
                        req_d.ac = psw_q.ac;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmr_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the last counted cycle still wins.
                if (valid_out) begin
                    rsp_d.des1 = des1;
                    rsp_d.des2 = des2;
                    rsp_d.des3 = des3;
                    rsp_d.acc  = des_acc;
                    rsp_d.err  = 1'b0;
                    psw_d.cy   = desCy;
                    psw_d.ac   = desAC;
                    psw_d.ov   = desOv;
                    state_d    = ST_RESP;
                end else if (tmr_q == TMR_LAST) begin
                    rsp_d     = '0;
                    rsp_d.err = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign op_code      = req_q.op;
    assign src1         = req_q.src1;
    assign src2         = req_q.src2;
    assign src3         = req_q.src3;
    assign srcCy        = req_q.cy;
    assign srcAc        = req_q.ac;
    assign bit_in       = req_q.bit_in;
    assign valid_in     = (state_q == ST_ISSUE);

    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_des1     = rsp_q.des1;
    assign rsp_des2     = rsp_q.des2;
    assign rsp_des3     = rsp_q.des3;
    assign rsp_acc      = rsp_q.acc;
    assign rsp_err      = rsp_q.err;

    assign psw_cy       = psw_q.cy;
    assign psw_ac       = psw_q.ac;
    assign psw_ov       = psw_q.ov;
    assign err_spurious = spur_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a stub ALU and a response scoreboard.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = '0;
    logic [7:0] cmd_src1 = '0, cmd_src2 = '0, cmd_src3 = '0;
    logic       cmd_cy = 1'b0, cmd_ac = 1'b0, cmd_bit = 1'b0, cmd_use_psw = 1'b0;
    logic [3:0] op_code;
    logic [7:0] src1, src2, src3;
    logic       srcCy, srcAc, bit_in, valid_in;
    logic [7:0] des1 = '0, des2 = '0, des3 = '0, des_acc = '0;
    logic       desCy = 1'b0, desAC = 1'b0, desOv = 1'b0, valid_out = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_des1, rsp_des2, rsp_des3, rsp_acc;
    logic       rsp_err, psw_cy, psw_ac, psw_ov, err_spurious;

    alu_issue_ctrl #(.CMD_DEPTH(4), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_src3(cmd_src3),
        .cmd_cy(cmd_cy), .cmd_ac(cmd_ac), .cmd_bit(cmd_bit), .cmd_use_psw(cmd_use_psw),
        .op_code(op_code), .src1(src1), .src2(src2), .src3(src3),
        .srcCy(srcCy), .srcAc(srcAc), .bit_in(bit_in), .valid_in(valid_in),
        .des1(des1), .des2(des2), .des3(des3), .des_acc(des_acc),
        .desCy(desCy), .desAC(desAC), .desOv(desOv), .valid_out(valid_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_des1(rsp_des1), .rsp_des2(rsp_des2), .rsp_des3(rsp_des3), .rsp_acc(rsp_acc),
        .rsp_err(rsp_err), .psw_cy(psw_cy), .psw_ac(psw_ac), .psw_ov(psw_ov),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] d1, d2, d3, acc;
        logic       cy, ac, ov;
    } res_t;

    typedef struct packed {
        logic [7:0] d1, d2, d3, acc;
        logic       err;
    } exp_t;

    // Reference ALU behaviour: adder with optional carry-in, plus fields that
    // echo the request so carry routing is visible in the response.
    function automatic res_t calc(input logic [3:0] op, input logic [7:0] s1, s2, s3,
                                  input logic cy, ac, b);
        res_t       r;
        logic       ci;
        logic [8:0] sum;
        logic [4:0] nib;
        ci   = (op == 4'h2) ? cy : 1'b0;
        sum  = {1'b0, s1} + {1'b0, s2} + {8'd0, ci};
        nib  = {1'b0, s1[3:0]} + {1'b0, s2[3:0]} + {4'd0, ci};
        r.d1  = sum[7:0];
        r.d2  = s2 ^ s3;
        r.d3  = {op, 1'b0, b, ac, cy};
        r.acc = ~s1;
        r.cy  = sum[8];
        r.ac  = nib[4];
        r.ov  = b;
        return r;
    endfunction

    // Stub ALU: answers alu_lat cycles after valid_in when enabled.
    logic alu_en   = 1'b1;
    int   alu_lat  = 3;
    logic spur_req = 1'b0;
    int   alu_cnt  = 0;
    res_t alu_res;

    always @(posedge clk) begin
        #2;
        valid_out = spur_req;
        if (valid_in) begin
            if (alu_en) begin
                alu_res = calc(op_code, src1, src2, src3, srcCy, srcAc, bit_in);
                alu_cnt = alu_lat;
            end
        end else if (alu_cnt > 0) begin
            alu_cnt = alu_cnt - 1;
            if (alu_cnt == 0) begin
                valid_out = 1'b1;
                des1      = alu_res.d1;
                des2      = alu_res.d2;
                des3      = alu_res.d3;
                des_acc   = alu_res.acc;
                desCy     = alu_res.cy;
                desAC     = alu_res.ac;
                desOv     = alu_res.ov;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    logic m_cy = 1'b0, m_ac = 1'b0, m_ov = 1'b0;

    logic [3:0] bp_op [5] = '{4'h3, 4'h2, 4'h5, 4'h9, 4'h1};
    logic [7:0] bp_s1 [5] = '{8'h11, 8'h7F, 8'hA5, 8'h00, 8'hC8};
    logic [7:0] bp_s2 [5] = '{8'h22, 8'h01, 8'h5A, 8'h00, 8'h48};
    logic [7:0] bp_s3 [5] = '{8'h33, 8'hFF, 8'h0F, 8'hC3, 8'h00};
    logic       bp_cy [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       bp_b  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // mode: 0 = no response expected, 1 = ALU result, 2 = timeout
    task automatic send(input logic [3:0] op, input logic [7:0] s1, s2, s3,
                        input logic cy, ac, b, up, input int mode, output int t_acc);
        logic ecy, eac, acc;
        res_t r;
        exp_t e;
        int   n;
        ecy = up ? m_cy : cy;
        eac = up ? m_ac : ac;
        if (mode == 1) begin
            r = calc(op, s1, s2, s3, ecy, eac, b);
            e = '{r.d1, r.d2, r.d3, r.acc, 1'b0};
            sb_q.push_back(e);
            m_cy = r.cy; m_ac = r.ac; m_ov = r.ov;
        end else if (mode == 2) begin
            e = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
            sb_q.push_back(e);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_src1 = s1; cmd_src2 = s2; cmd_src3 = s3;
        cmd_cy = cy; cmd_ac = ac; cmd_bit = b; cmd_use_psw = up;
        acc = 1'b0; n = 0; t_acc = cyc;
        while (!acc && n < 50) begin
            acc   = cmd_ready;
            t_acc = cyc;
            step();
            n++;
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_vin(output int t);
        int n = 0;
        while (!valid_in && n < 40) begin step(); n++; end
        chk("vin_seen", {31'd0, valid_in}, 32'd1);
        t = cyc;
    endtask

    task automatic wait_rsp(input string tag, output int t);
        int   n = 0;
        exp_t e;
        while (!rsp_valid && n < 60) begin step(); n++; end
        chk({tag, "_seen"}, {31'd0, rsp_valid}, 32'd1);
        t = cyc;
        if (rsp_valid) begin
            chk({tag, "_sb"}, {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk({tag, "_des1"}, {24'd0, rsp_des1}, {24'd0, e.d1});
                chk({tag, "_des2"}, {24'd0, rsp_des2}, {24'd0, e.d2});
                chk({tag, "_des3"}, {24'd0, rsp_des3}, {24'd0, e.d3});
                chk({tag, "_acc"},  {24'd0, rsp_acc},  {24'd0, e.acc});
                chk({tag, "_err"},  {31'd0, rsp_err},  {31'd0, e.err});
            end
        end
        step();
    endtask

    initial begin
        int   ta, tv, tv2, tr, cnt;
        logic [7:0] h_d1, h_acc;

        // reset values
        step(); step();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_valid_in",  {31'd0, valid_in}, 32'd0);
        chk("rst_req", {8'd0, op_code, src1, src2, src3[3:0]}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp", {rsp_des1, rsp_des2, rsp_des3, rsp_acc}, 32'd0);
        chk("rst_psw", {29'd0, psw_cy, psw_ac, psw_ov}, 32'd0);
        chk("rst_spur", {31'd0, err_spurious}, 32'd0);
        reset = 1'b1;
        step();

        // single op, ALU answers 3 cycles after valid_in
        rsp_ready = 1'b1; alu_lat = 3;
        send(4'h1, 8'h0F, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, ta);
        wait_vin(tv);
        chk("single_vin_lat", tv - ta, 32'd2);
        chk("single_op", {28'd0, op_code}, 32'h1);
        chk("single_src", {16'd0, src1, src2}, 32'h0F01);
        chk("single_des1_raw", {24'd0, rsp_des1}, 32'd0);
        wait_rsp("single", tr);
        chk("single_rsp_lat", tr - tv, 32'd4);
        chk("single_psw", {29'd0, psw_cy, psw_ac, psw_ov}, {29'd0, m_cy, m_ac, m_ov});

        // carry chaining through the PSW
        alu_lat = 1;
        send(4'h2, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1, ta);
        send(4'h2, 8'hF0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1, ta);
        wait_vin(tv);
        chk("chainA_srcCy", {31'd0, srcCy}, 32'd0);
        wait_rsp("chainA", tr);
        wait_vin(tv2);
        chk("chainB_srcCy", {31'd0, srcCy}, 32'd1);
        chk("chainB_psw_cy", {31'd0, psw_cy}, 32'd1);
        chk("issue_spacing", tv2 - tv, 32'd4);
        wait_rsp("chainB", tr);

        // result on the last counted WAIT cycle beats the timeout
        alu_lat = 4;
        send(4'h3, 8'h40, 8'h02, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1, ta);
        wait_vin(tv);
        wait_rsp("edge", tr);
        chk("edge_rsp_lat", tr - tv, 32'd5);

        // timeout: ALU silent, PSW left alone
        alu_en = 1'b0;
        chk("pre_to_psw", {29'd0, psw_cy, psw_ac, psw_ov}, {29'd0, m_cy, m_ac, m_ov});
        send(4'h1, 8'h33, 8'h44, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 2, ta);
        wait_vin(tv);
        wait_rsp("tmo", tr);
        chk("tmo_rsp_lat", tr - tv, 32'd5);
        chk("tmo_psw", {29'd0, psw_cy, psw_ac, psw_ov}, {29'd0, m_cy, m_ac, m_ov});
        alu_en = 1'b1;

        // backpressure: five commands, FIFO fills, payload holds
        rsp_ready = 1'b0; alu_lat = 2;
        for (int i = 0; i < 5; i++)
            send(bp_op[i], bp_s1[i], bp_s2[i], bp_s3[i], bp_cy[i], 1'b0, bp_b[i], 1'b0, 1, ta);
        chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        cnt = 0;
        while (!rsp_valid && cnt < 40) begin step(); cnt++; end
        h_d1 = rsp_des1; h_acc = rsp_acc;
        step(); step(); step();
        chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_hold_payload", {16'd0, rsp_des1, rsp_acc}, {16'd0, h_d1, h_acc});
        chk("bp_still_full", {31'd0, cmd_ready}, 32'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) wait_rsp($sformatf("bp%0d", i), tr);
        chk("bp_psw", {29'd0, psw_cy, psw_ac, psw_ov}, {29'd0, m_cy, m_ac, m_ov});

        // spurious valid_out while idle
        step();
        chk("spur_before", {31'd0, err_spurious}, 32'd0);
        spur_req = 1'b1;
        step();
        spur_req = 1'b0;
        step(); step();
        chk("spur_set", {31'd0, err_spurious}, 32'd1);
        chk("spur_no_rsp", {31'd0, rsp_valid}, 32'd0);

        // reset during WAIT
        alu_lat = 6;
        send(4'h2, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, ta);
        send(4'h1, 8'h05, 8'h06, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 0, ta);
        wait_vin(tv);
        step(); step();
        reset = 1'b0;
        #1;
        chk("arst_valid_in", {31'd0, valid_in}, 32'd0);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_req", {8'd0, op_code, src1, src2, src3[3:0]}, 32'd0);
        chk("arst_psw", {29'd0, psw_cy, psw_ac, psw_ov}, 32'd0);
        chk("arst_spur", {31'd0, err_spurious}, 32'd0);
        chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        step(); step();
        reset = 1'b1;
        m_cy = 1'b0; m_ac = 1'b0; m_ov = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (valid_in) cnt++;
            step();
        end
        chk("arst_fifo_empty", cnt, 32'd0);
        chk("late_result_spur", {31'd0, err_spurious}, 32'd1);

        alu_lat = 1;
        send(4'h2, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1, ta);
        wait_vin(tv);
        chk("post_rst_srcCy", {30'd0, srcCy, srcAc}, 32'd0);
        wait_rsp("post_rst", tr);
        chk("post_rst_psw", {29'd0, psw_cy, psw_ac, psw_ov}, {29'd0, m_cy, m_ac, m_ov});
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
